// File: rtl/var_delay_line.sv
// Strobed variable delay line: circular buffer with read-before-write addressing.
// History newer than the requested delay is masked to zero, so uninitialised RAM never leaks out.
module var_delay_line #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     sample_en,
   input  logic                     flush,
   input  logic [ADDR_W:0]          i_delay,
   input  logic signed [DATA_W-1:0] i_signal_sample,
   output logic signed [DATA_W-1:0] o_delayed_sample,
   output logic                     o_valid,
   output logic                     o_filled
);

   localparam int MAX_DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] MAX_DELAY = {ADDR_W{1'b1}};

   logic [DATA_W-1:0]        mem [MAX_DEPTH];
   logic [ADDR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]        fill_q, fill_d;
   logic signed [DATA_W-1:0] out_q, out_d;
   logic                     valid_q, valid_d;
   logic [ADDR_W-1:0]        deff;
   logic [ADDR_W-1:0]        rd_addr;
   logic                     accept;

   always_comb begin
      accept   = sample_en & ~flush;
      // Any delay with the top bit set exceeds the buffer and clamps to the deepest tap.
      deff     = i_delay[ADDR_W] ? MAX_DELAY : i_delay[ADDR_W-1:0];
      rd_addr  = wr_ptr_q - deff;
      wr_ptr_d = wr_ptr_q;
      fill_d   = fill_q;
      out_d    = out_q;
      valid_d  = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         fill_d   = '0;
         out_d    = '0;
      end else if (sample_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
         fill_d   = (fill_q == MAX_DELAY) ? fill_q : fill_q + 1'b1;
         valid_d  = 1'b1;
         if (deff == '0) begin
            out_d = i_signal_sample;
         end else if (deff > fill_q) begin
            out_d = '0;
         end else begin
            out_d = mem[rd_addr];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         fill_q   <= '0;
         out_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         fill_q   <= fill_d;
         out_q    <= out_d;
         valid_q  <= valid_d;
      end
   end

   // RAM is deliberately unreset; the fill-count mask covers its contents.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr_q] <= i_signal_sample;
      end
   end

   assign o_delayed_sample = out_q;
   assign o_valid          = valid_q;
   assign o_filled         = (fill_q == MAX_DELAY);

endmodule

// File: tb/tb_var_delay_line.sv
// Bench for var_delay_line: vector table plus directed sequences, checked by a
// negedge monitor against an expected-sample queue and an unbounded history model.
module tb_var_delay_line;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               sample_en = 1'b0;
   logic               flush = 1'b0;
   logic [6:0]         i_delay = '0;
   logic signed [15:0] i_signal_sample = '0;
   logic signed [15:0] o_delayed_sample;
   logic               o_valid;
   logic               o_filled;

   int checks = 0;
   int errors = 0;

   logic [15:0]        exp_q[$];
   logic signed [15:0] hold_exp = '0;
   logic signed [15:0] hist[$];
   int                 cnt = 0;

   typedef struct {
      logic [6:0]         dly;
      logic signed [15:0] x;
      logic signed [15:0] exp;
   } vec_t;

   vec_t vecs[10];
   logic signed [15:0] data_tab[210];

   var_delay_line #(.DATA_W(16), .ADDR_W(6)) dut (
      .clk(clk),
      .rst(rst),
      .sample_en(sample_en),
      .flush(flush),
      .i_delay(i_delay),
      .i_signal_sample(i_signal_sample),
      .o_delayed_sample(o_delayed_sample),
      .o_valid(o_valid),
      .o_filled(o_filled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic signed [15:0] model_out(input logic [6:0] d, input logic signed [15:0] x);
      int deff;
      int fc;
      deff = (d > 7'd63) ? 63 : int'(d);
      fc   = (cnt > 63) ? 63 : cnt;
      if (deff == 0) return x;
      if (deff > fc) return '0;
      return hist[cnt - deff];
   endfunction

   task automatic model_clear();
      hist.delete();
      cnt = 0;
      hold_exp = '0;
   endtask

   // Drivers run at posedge+1; the monitor samples at negedge.
   always @(negedge clk) begin
      logic signed [15:0] e;
      if (rst) begin
         chk("rst_valid", int'(o_valid), 0);
         chk("rst_out", int'(o_delayed_sample), 0);
         chk("rst_filled", int'(o_filled), 0);
      end else begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", int'(o_valid), 1);
            chk("sample", int'(o_delayed_sample), int'(e));
         end else begin
            chk("valid_idle", int'(o_valid), 0);
            chk("hold", int'(o_delayed_sample), int'(hold_exp));
         end
         chk("filled", int'(o_filled), (cnt >= 63) ? 1 : 0);
      end
   end

   task automatic strobe(input logic [6:0] d, input logic signed [15:0] x,
                         input bit has_exp, input logic signed [15:0] texp);
      logic signed [15:0] e;
      i_delay = d;
      i_signal_sample = x;
      sample_en = 1'b1;
      flush = 1'b0;
      e = has_exp ? texp : model_out(d, x);
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      hold_exp = e;
      hist.push_back(x);
      cnt++;
      sample_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic flush_cycle(input bit en);
      sample_en = en;
      flush = 1'b1;
      i_signal_sample = 16'sh7abc;
      @(posedge clk);
      #1;
      model_clear();
      flush = 1'b0;
      sample_en = 1'b0;
   endtask

   // Reset is raised between edges and checked before the next clock edge.
   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      model_clear();
      #1;
      chk("async_rst_out", int'(o_delayed_sample), 0);
      chk("async_rst_valid", int'(o_valid), 0);
      chk("async_rst_filled", int'(o_filled), 0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{7'd0,   -16'sd32768, -16'sd32768};
      vecs[1] = '{7'd0,    16'sd32767,  16'sd32767};
      vecs[2] = '{7'd0,    16'sd5,      16'sd5};
      vecs[3] = '{7'd2,    16'sd100,    16'sd32767};
      vecs[4] = '{7'd4,    16'sd7,     -16'sd32768};
      vecs[5] = '{7'd6,    16'sd9,      16'sd0};
      vecs[6] = '{7'd1,    16'sd11,     16'sd9};
      vecs[7] = '{7'd7,   -16'sd1,     -16'sd32768};
      vecs[8] = '{7'd127,  16'sd0,      16'sd0};
      vecs[9] = '{7'd3,    16'sd42,     16'sd11};

      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back table vectors, including full-scale pass-through.
      foreach (vecs[i]) strobe(vecs[i].dly, vecs[i].x, 1'b1, vecs[i].exp);
      idle(3);

      // Legacy 64-stage timing: delay 63, one strobe every 64 clocks.
      do_reset();
      for (int n = 1; n <= 100; n++) begin
         strobe(7'd63, 16'(n), 1'b1, (n <= 63) ? 16'sd0 : 16'(n - 63));
         idle(63);
      end

      // Mid-stream delay change takes effect on the very next strobe.
      do_reset();
      for (int n = 1; n <= 20; n++) strobe(7'd10, 16'(n), 1'b1, (n <= 10) ? 16'sd0 : 16'(n - 10));
      strobe(7'd3, 16'sd21, 1'b1, 16'sd18);
      idle(2);

      // Flush wins over a simultaneous strobe; history restarts from empty.
      do_reset();
      for (int n = 1; n <= 30; n++) strobe(7'd5, 16'(n), 1'b0, '0);
      flush_cycle(1'b1);
      idle(1);
      for (int n = 1; n <= 5; n++) strobe(7'd5, 16'(500 + n), 1'b1, 16'sd0);
      strobe(7'd5, 16'sd506, 1'b1, 16'sd501);
      idle(1);

      // Asynchronous reset mid-stream, then delay 4 from empty history.
      for (int n = 1; n <= 8; n++) strobe(7'd2, 16'(n * 3), 1'b0, '0);
      do_reset();
      for (int n = 1; n <= 4; n++) strobe(7'd4, 16'(-n), 1'b1, 16'sd0);
      strobe(7'd4, 16'sd77, 1'b1, -16'sd1);
      idle(1);

      // Over-range delays clamp to 63; identical data across three runs wraps the pointer.
      foreach (data_tab[i]) data_tab[i] = 16'($urandom_range(0, 65535));
      for (int r = 0; r < 3; r++) begin
         do_reset();
         for (int n = 0; n < 210; n++) begin
            strobe((r == 0) ? 7'd63 : (r == 1) ? 7'd64 : 7'd127, data_tab[n], 1'b1,
                   (n < 63) ? 16'sd0 : data_tab[n - 63]);
         end
         idle(2);
      end

      // Random delays, gaps and occasional flushes against the history model.
      do_reset();
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 39) == 0) flush_cycle(1'($urandom_range(0, 1)));
         strobe(7'($urandom_range(0, 127)), 16'($urandom_range(0, 65535)), 1'b0, '0);
         idle($urandom_range(0, 2));
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
